// File: rtl/uart_rx_if.sv
// Host-side bus of the UART receiver: read strobe, FIFO head and status, error strobes.
// Latency: none (plain wires).
// Backpressure: none; the host pops with a 1-clk read strobe when dataPresent is high.
//
// master = host (drives read), slave = receiver (drives everything else).
interface uart_rx_if;
   logic       read;
   logic [7:0] dataOut;
   logic       dataPresent;
   logic       halfFull;
   logic       full;
   logic       frameError;
   logic       overrun;

   modport master (
      output read,
      input  dataOut, dataPresent, halfFull, full, frameError, overrun
   );

   modport slave (
      input  read,
      output dataOut, dataPresent, halfFull, full, frameError, overrun
   );
endinterface

// File: rtl/fifo.sv
// Generic synchronous FIFO with a first-word fall-through read port.
// Latency: a pushed word is visible on rd_dat/rd_vld the clock after the push.
// Backpressure: push while full and pop while empty are ignored; wr_rdy/rd_vld report space/data.
//
// Ports: clk, rst (sync, active high) | wr_vld/wr_dat/wr_rdy push side |
//        rd_vld/rd_dat/rd_rdy pop side | count = current occupancy (0..DEPTH).
// DEPTH must be a power of two so the pointers wrap naturally.
module fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_vld,
   input  logic [WIDTH-1:0] wr_dat,
   output logic             wr_rdy,
   output logic             rd_vld,
   input  logic             rd_rdy,
   output logic [WIDTH-1:0] rd_dat,
   output logic [AW:0]      count
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             push, pop;

   assign wr_rdy = (cnt_q != FULL_CNT);
   assign rd_vld = (cnt_q != '0);
   assign rd_dat = mem_q[rd_ptr_q];
   assign count  = cnt_q;
   assign push   = wr_vld & wr_rdy;
   assign pop    = rd_rdy & rd_vld;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_dat;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage is not reset; only the pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8n1 UART receiver, 16x oversampled, good bytes queued in a 16-entry FWFT FIFO.
// Latency: FIFO write 1 clk after the stop-bit sample strobe; dataPresent 2 clk after it.
// Backpressure: none toward the line; a byte arriving while the FIFO is full is dropped with an overrun pulse.
//
// Ports: clk, rst (sync, active high) | x16BaudStrobe 1-clk strobe at 16x baud |
//        serialIn async line (idle high) | host: uart_rx_if.slave
//        (read, dataOut, dataPresent, halfFull, full, frameError, overrun).
// SYNC_STAGES must be at least 2.
module uart_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic x16BaudStrobe,
   input  logic serialIn,
   uart_rx_if.slave host
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BRK   = 3'd4
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [2:0]             bit_q, bit_d;
   logic [7:0]             shift_q, shift_d;
   logic                   good_q, good_d;
   logic                   ferr_q, ferr_d;
   logic                   line;

   logic                   fifo_wr_vld;
   logic                   fifo_wr_rdy;
   logic [4:0]             fifo_count;

   assign line   = sync_q[SYNC_STAGES-1];
   assign sync_d = {sync_q[SYNC_STAGES-2:0], serialIn};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      good_d  = 1'b0;
      ferr_d  = 1'b0;
      if (x16BaudStrobe) begin
         case (state_q)
            S_IDLE: begin
               if (!line) begin
                  state_d = S_START;
                  cnt_d   = '0;
               end
            end
            S_START: begin
               cnt_d = cnt_q + 4'd1;
               // Mid-point of the start bit: a high line here was only a glitch.
               if (cnt_q == 4'd7) begin
                  if (line) begin
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_DATA;
                     cnt_d   = '0;
                     bit_d   = '0;
                  end
               end
            end
            S_DATA: begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  shift_d = {line, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_d = S_STOP;
                  end
               end
            end
            S_STOP: begin
               cnt_d = cnt_q + 4'd1;
               // Back to IDLE on the sample strobe so an immediately following start is caught.
               if (cnt_q == 4'd15) begin
                  if (line) begin
                     good_d  = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = S_BRK;
                  end
               end
            end
            S_BRK: begin
               // Hold here through a break so a long low line reports only one error.
               if (line) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '1;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         good_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         good_q  <= good_d;
         ferr_q  <= ferr_d;
      end
   end

   // good_q marks the write cycle; shift_q is stable then because the next frame
   // cannot shift a data bit for at least 24 strobes.  Full is judged in this same
   // cycle, so a simultaneous host read does not rescue the byte.
   assign fifo_wr_vld      = good_q & ~rst;
   assign host.overrun     = good_q & ~fifo_wr_rdy & ~rst;
   assign host.frameError  = ferr_q;
   assign host.full        = ~fifo_wr_rdy;
   assign host.halfFull    = (fifo_count >= 5'd8);

   fifo #(
      .WIDTH (8),
      .DEPTH (16)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_vld (fifo_wr_vld),
      .wr_dat (shift_q),
      .wr_rdy (fifo_wr_rdy),
      .rd_vld (host.dataPresent),
      .rd_rdy (host.read),
      .rd_dat (host.dataOut),
      .count  (fifo_count)
   );

endmodule
